// File: rtl/security_alarm_ctrl.sv
// House alarm controller: exit/entry delays, timed siren and a police-dispatch
// request/acknowledge handshake, all outputs registered alongside the state.
module security_alarm_ctrl #(
  parameter int NSENS      = 6,
  parameter int DOOR_IDX   = 0,
  parameter int EXIT_DLY   = 16,
  parameter int ENTRY_DLY  = 8,
  parameter int ALARM_TIME = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             main_sw,
  input  logic [NSENS-1:0] s1,
  input  logic             pol_ack,
  output logic             alarm,
  output logic             lights,
  output logic             call_to_pol,
  output logic             video_camera,
  output logic [2:0]       state_o
);

  localparam int MAX_A = (EXIT_DLY > ENTRY_DLY) ? EXIT_DLY : ENTRY_DLY;
  localparam int MAX_D = (MAX_A > ALARM_TIME) ? MAX_A : ALARM_TIME;
  localparam int CW    = (MAX_D > 1) ? $clog2(MAX_D) : 1;

  localparam logic [CW-1:0]    EXIT_LAST  = CW'(EXIT_DLY - 1);
  localparam logic [CW-1:0]    ENTRY_LAST = CW'(ENTRY_DLY - 1);
  localparam logic [CW-1:0]    ALARM_LAST = CW'(ALARM_TIME - 1);
  localparam logic [NSENS-1:0] DOOR_MASK  = NSENS'(1) << DOOR_IDX;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'b000,
    ST_EXIT     = 3'b001,
    ST_ARMED    = 3'b010,
    ST_ENTRY    = 3'b011,
    ST_ALARM    = 3'b100
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          notified_q, notified_d;
  logic          alarm_d, lights_d, call_d, camera_d;
  logic          door, other, timed;

  assign door  = s1[DOOR_IDX];
  assign other = |(s1 & ~DOOR_MASK);

  always_comb begin
    state_d = ST_DISARMED;
    timed   = 1'b0;
    case (state_q)
      ST_DISARMED: state_d = main_sw ? ST_EXIT : ST_DISARMED;
      ST_EXIT: begin
        timed = 1'b1;
        if (!main_sw)                state_d = ST_DISARMED;
        else if (cnt_q == EXIT_LAST) state_d = ST_ARMED;
        else                         state_d = ST_EXIT;
      end
      ST_ARMED: begin
        if (!main_sw)   state_d = ST_DISARMED;
        else if (other) state_d = ST_ALARM;
        else if (door)  state_d = ST_ENTRY;
        else            state_d = ST_ARMED;
      end
      ST_ENTRY: begin
        timed = 1'b1;
        if (!main_sw)                 state_d = ST_DISARMED;
        else if (other)               state_d = ST_ALARM;
        else if (cnt_q == ENTRY_LAST) state_d = ST_ALARM;
        else                          state_d = ST_ENTRY;
      end
      ST_ALARM: begin
        timed = 1'b1;
        if (!main_sw)                 state_d = ST_DISARMED;
        else if (cnt_q == ALARM_LAST) state_d = ST_ARMED;
        else                          state_d = ST_ALARM;
      end
      default: state_d = ST_DISARMED;
    endcase

    cnt_d = (timed && (state_d == state_q)) ? cnt_q + CW'(1) : '0;

    // notified survives ALARM->ARMED->ALARM so a re-trigger does not re-call
    if (state_d == ST_DISARMED)      notified_d = 1'b0;
    else if (call_to_pol && pol_ack) notified_d = 1'b1;
    else                             notified_d = notified_q;

    alarm_d  = (state_d == ST_ALARM);
    lights_d = (state_d == ST_EXIT) || (state_d == ST_ENTRY) || (state_d == ST_ALARM);
    camera_d = (state_d == ST_ENTRY) || (state_d == ST_ALARM);
    call_d   = (state_d == ST_ALARM) && !notified_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_DISARMED;
      cnt_q        <= '0;
      notified_q   <= 1'b0;
      alarm        <= 1'b0;
      lights       <= 1'b0;
      call_to_pol  <= 1'b0;
      video_camera <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      notified_q   <= notified_d;
      alarm        <= alarm_d;
      lights       <= lights_d;
      call_to_pol  <= call_d;
      video_camera <= camera_d;
    end
  end

  assign state_o = state_q;

endmodule
